// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch (I), load/store (D) and memory-side signals around the arbiter.
// slave = arbiter view, master = the core/memory environment driving it.
interface mem_port_arbiter_if #(parameter int ADDRW = 12);
    logic             i_req;
    logic [ADDRW-1:0] i_addr;
    logic             i_gnt;
    logic             i_rvalid;
    logic [31:0]      i_rdata;
    logic             i_err;

    logic             d_req;
    logic             d_we;
    logic [2:0]       d_funct3;
    logic [ADDRW-1:0] d_addr;
    logic [31:0]      d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic             d_err;

    logic             m_we;
    logic [2:0]       m_funct3;
    logic [ADDRW-1:0] m_addr;
    logic [31:0]      m_wdata;
    logic [31:0]      m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_we, m_funct3, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_we, m_funct3, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port byte memory: D-priority with an
// anti-starvation override for I, alignment checking, fixed 2-cycle slots.
module mem_port_arbiter #(
    parameter int ADDRW      = 12,
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_nx;
    logic             i_win, d_win;
    logic             i_err_c, d_err_c;
    logic [CW-1:0]    starve_cnt;

    logic             owner_q;      // 0 = I, 1 = D
    logic             we_q;
    logic             err_q;
    logic [2:0]       f3_q;
    logic [ADDRW-1:0] addr_q;
    logic [31:0]      wdata_q;

    logic             i_rv_q, d_rv_q, rerr_q;
    logic [31:0]      rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant is combinational in IDLE; rst gates it so outputs are 0 during reset.
    always_comb begin
        state_nx = state;
        i_win    = 1'b0;
        d_win    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (bus.i_req || bus.d_req)) begin
                    i_win    = bus.i_req && (!bus.d_req || starve_cnt == CW'(STARVE_MAX));
                    d_win    = !i_win;
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign i_err_c = |bus.i_addr[1:0];

    always_comb begin
        case (bus.d_funct3[1:0])
            2'b00:   d_err_c = 1'b0;
            2'b01:   d_err_c = bus.d_addr[0];
            2'b10:   d_err_c = |bus.d_addr[1:0];
            default: d_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (i_win) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= i_err_c;
            f3_q    <= 3'b010;
            addr_q  <= bus.i_addr;
            wdata_q <= '0;
        end else if (d_win) begin
            owner_q <= 1'b1;
            we_q    <= bus.d_we;
            err_q   <= d_err_c;
            f3_q    <= bus.d_funct3;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
        end
    end

    // An in-flight access killed by reset never produces rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            i_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            if (state == ACCESS) begin
                rdata_q <= (we_q || err_q) ? 32'h0 : bus.m_rdata;
                rerr_q  <= err_q;
                i_rv_q  <= ~owner_q;
                d_rv_q  <= owner_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         starve_cnt <= '0;
        else if (!bus.i_req || i_win)    starve_cnt <= '0;
        else if (d_win && starve_cnt != CW'(STARVE_MAX))
                                         starve_cnt <= starve_cnt + CW'(1);
    end

    assign bus.i_gnt    = i_win;
    assign bus.d_gnt    = d_win;
    assign bus.i_rvalid = i_rv_q;
    assign bus.d_rvalid = d_rv_q;
    assign bus.i_rdata  = i_rv_q ? rdata_q : 32'h0;
    assign bus.d_rdata  = d_rv_q ? rdata_q : 32'h0;
    assign bus.i_err    = i_rv_q & rerr_q;
    assign bus.d_err    = d_rv_q & rerr_q;

    assign bus.m_we     = (state == ACCESS) & we_q & ~err_q;
    assign bus.m_funct3 = f3_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requests push expected responses, a negedge monitor pops
// and compares on every rvalid, including grant-to-rvalid latency.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRW(12)) bus ();

    mem_port_arbiter #(.ADDRW(12), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte memory model: combinational read with sign/zero extension.
    logic [7:0] mem [0:4095];
    logic [7:0] b0, b1, b2, b3;
    assign b0 = mem[bus.m_addr];
    assign b1 = mem[bus.m_addr + 12'd1];
    assign b2 = mem[bus.m_addr + 12'd2];
    assign b3 = mem[bus.m_addr + 12'd3];

    always_comb begin
        bus.m_rdata = 32'h0;
        case (bus.m_funct3[1:0])
            2'b00:   bus.m_rdata = bus.m_funct3[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   bus.m_rdata = bus.m_funct3[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            2'b10:   bus.m_rdata = {b3, b2, b1, b0};
            default: bus.m_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.m_we) begin
            mem[bus.m_addr] <= bus.m_wdata[7:0];
            if (bus.m_funct3[1:0] != 2'b00) mem[bus.m_addr + 12'd1] <= bus.m_wdata[15:8];
            if (bus.m_funct3[1:0] == 2'b10) begin
                mem[bus.m_addr + 12'd2] <= bus.m_wdata[23:16];
                mem[bus.m_addr + 12'd3] <= bus.m_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   i_gnt_cyc = 0;
    int   d_gnt_cyc = 0;
    bit   both_gnt = 1'b0;
    bit   we_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // rvalid is checked before recording new grants: both can occur in one cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.i_rvalid) begin
            if (iq.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                chk({e.name, "_rdata"}, bus.i_rdata, e.rdata);
                chk({e.name, "_err"}, {31'h0, bus.i_err}, {31'h0, e.err});
                chk({e.name, "_lat"}, cyc - i_gnt_cyc, 32'd2);
            end
        end
        if (bus.d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                chk({e.name, "_rdata"}, bus.d_rdata, e.rdata);
                chk({e.name, "_err"}, {31'h0, bus.d_err}, {31'h0, e.err});
                chk({e.name, "_lat"}, cyc - d_gnt_cyc, 32'd2);
            end
        end
        if (bus.i_gnt) i_gnt_cyc = cyc;
        if (bus.d_gnt) d_gnt_cyc = cyc;
        if (bus.i_gnt && bus.d_gnt) both_gnt = 1'b1;
        if (bus.m_we) we_seen = 1'b1;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_i_gnt"},    {31'h0, bus.i_gnt},    32'h0);
        chk({tag, "_i_rvalid"}, {31'h0, bus.i_rvalid}, 32'h0);
        chk({tag, "_i_rdata"},  bus.i_rdata,           32'h0);
        chk({tag, "_i_err"},    {31'h0, bus.i_err},    32'h0);
        chk({tag, "_d_gnt"},    {31'h0, bus.d_gnt},    32'h0);
        chk({tag, "_d_rvalid"}, {31'h0, bus.d_rvalid}, 32'h0);
        chk({tag, "_d_rdata"},  bus.d_rdata,           32'h0);
        chk({tag, "_d_err"},    {31'h0, bus.d_err},    32'h0);
        chk({tag, "_m_we"},     {31'h0, bus.m_we},     32'h0);
        chk({tag, "_m_funct3"}, {29'h0, bus.m_funct3}, 32'h0);
        chk({tag, "_m_addr"},   {20'h0, bus.m_addr},   32'h0);
        chk({tag, "_m_wdata"},  bus.m_wdata,           32'h0);
    endtask

    // Issue one request, push its expected response, hold req until granted.
    task automatic issue(input bit is_d, input bit we, input logic [2:0] f3,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input string name);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (is_d) begin
            dq.push_back('{exp_rd, exp_err, name});
            bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = addr; bus.d_wdata = wdata;
            bus.d_req = 1'b1;
        end else begin
            iq.push_back('{exp_rd, exp_err, name});
            bus.i_addr = addr;
            bus.i_req  = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_gnt : bus.i_gnt) begin got = 1'b1; break; end
        end
        if (!got) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
    endtask

    initial begin
        string seq;
        int    n;
        for (int a = 0; a < 4096; a++) mem[a] = a[7:0];
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_funct3 = '0; bus.d_addr = '0; bus.d_wdata = '0;

        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Store then fetch the same word.
        issue(1, 1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 0, "sw_010");
        issue(0, 0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 0, "fetch_010");

        // Byte store, signed/unsigned byte and half loads, illegal sizes.
        issue(1, 1, 3'b000, 12'h013, 32'h00000080, 32'h0, 0, "sb_013");
        issue(1, 0, 3'b000, 12'h013, 32'h0, 32'hFFFFFF80, 0, "lb_013");
        issue(1, 0, 3'b100, 12'h013, 32'h0, 32'h00000080, 0, "lbu_013");
        issue(1, 0, 3'b001, 12'h012, 32'h0, 32'hFFFF80AD, 0, "lh_012");
        issue(1, 0, 3'b101, 12'h012, 32'h0, 32'h000080AD, 0, "lhu_012");
        issue(1, 0, 3'b010, 12'h010, 32'h0, 32'h80ADBEEF, 0, "lw_010");
        issue(1, 0, 3'b011, 12'h010, 32'h0, 32'h0, 1, "size11_010");
        issue(1, 0, 3'b010, 12'h011, 32'h0, 32'h0, 1, "lw_011_mis");

        // Both requesters held: D x4 then forced I.
        seq = "";
        n = 0;
        bus.i_addr = 12'h010;
        bus.d_we = 0; bus.d_funct3 = 3'b010; bus.d_addr = 12'h010;
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 60 && n < 10; k++) begin
            @(negedge clk);
            if (bus.d_gnt) begin dq.push_back('{32'h80ADBEEF, 1'b0, "arb_d"}); seq = {seq, "D"}; n++; end
            if (bus.i_gnt) begin iq.push_back('{32'h80ADBEEF, 1'b0, "arb_i"}); seq = {seq, "I"}; n++; end
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        checks++;
        if (seq != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL arb_order: got=%s expected=DDDDIDDDDI", seq);
        end

        // Misaligned half store must not write.
        issue(1, 1, 3'b010, 12'h020, 32'hCAFEF00D, 32'h0, 0, "sw_020");
        repeat (2) @(posedge clk);
        we_seen = 1'b0;
        issue(1, 1, 3'b001, 12'h021, 32'h00001234, 32'h0, 1, "sh_021_mis");
        repeat (2) @(posedge clk);
        chk("sh_021_no_write", {31'h0, we_seen}, 32'h0);
        issue(1, 0, 3'b010, 12'h020, 32'h0, 32'hCAFEF00D, 0, "lw_020");

        // Fetch alignment.
        issue(0, 0, 3'b010, 12'h006, 32'h0, 32'h0, 1, "fetch_006_mis");
        issue(0, 0, 3'b010, 12'h004, 32'h0, 32'h07060504, 0, "fetch_004");

        // Reset during ACCESS of a load: no rvalid, outputs cleared at once.
        @(posedge clk); #1;
        bus.d_we = 0; bus.d_funct3 = 3'b010; bus.d_addr = 12'h014; bus.d_req = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.d_gnt) begin n = 1; break; end
        end
        chk("rst_load_gnt", n, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 12'h008;
        @(negedge clk);
        chk_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1 bus.i_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        issue(1, 0, 3'b010, 12'h010, 32'h0, 32'h80ADBEEF, 0, "lw_after_rst");

        repeat (6) @(posedge clk);
        chk("both_gnt_never", {31'h0, both_gnt}, 32'h0);
        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
